xm23_int_ctrl: RTL and testbench
================================

XM23_INT_CTRL -- requirements
Module: xm23_int_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DEV, default 5, the number of device interrupt sources (fixed order: 0 timer, 1 keyboard, 2 screen, 3 traffic light, 4 push button).
REQ-002 The block SHALL have parameter VECT_BASE, default 4'd0, added to the device index to form the vector number.
REQ-003 Clock  input  1  system clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 csr_tmr, csr_kb, csr_scr, csr_tl, csr_pb  input  8 each  device CSR images; bit0 = IE (interrupt enable), bit2 = DBA (data byte available).
REQ-006 dev_pri  input  15  3-bit priority per device, device n at [3n+2:3n].
REQ-007 cur_pri  input  3  current CPU priority from PSW[7:5].
REQ-008 pic_read  input  1  one-cycle acknowledge from the control unit that the presented request is being taken.
REQ-009 pic_out  output  8  request word: [7] valid, [6:4] priority, [3:0] vector number.
REQ-010 pend  output  5  per-device pending flags, for debug/LEDs.

Function
REQ-011 Pending flag n SHALL set on a 0->1 transition of device n DBA when device n IE = 1; a DBA held high SHALL NOT re-set a cleared flag.
REQ-012 A pending flag SHALL clear when its device's IE goes 0 or when that device is acknowledged; if the set and ack conditions coincide for the same device, the flag SHALL remain set.
REQ-013 FSM states: IDLE, ARB, PRESENT, ACK.
REQ-014 IDLE -> ARB when any pend bit is 1; else stay in IDLE.
REQ-015 ARB (one cycle): select the pending device with the highest dev_pri; latch winner index and priority; go to PRESENT if winner priority > cur_pri, else return to IDLE.
REQ-016 PRESENT: pic_out = {1, pri, VECT_BASE+index}, held stable; go to ACK on pic_read = 1.
REQ-017 PRESENT: if the winner's pending flag clears without pic_read, or cur_pri rises to >= winner priority, drop valid within 1 cycle and return to IDLE.
REQ-018 ACK (one cycle): clear winner pend; pic_out valid = 0; -> IDLE.
REQ-019 pic_read outside PRESENT SHALL be ignored.
REQ-020 Latency from DBA edge to pic_out[7] = 1 SHALL be 3 rising edges: pend set, ARB, PRESENT.
REQ-021 Priority comparison SHALL be unsigned 3-bit; priority 0 SHALL never be presented, because it is never > cur_pri >= 0.
REQ-022 A newly pending higher-priority device SHALL NOT pre-empt PRESENT; it is arbitrated after ACK or abort.

Reset
REQ-023 While Reset_n = 0: state = IDLE, pend = 0, pic_out = 8'h00, DBA edge registers = 0, round-robin pointer = 0.
REQ-024 Reset asserted mid-PRESENT SHALL drop pic_out[7] asynchronously; no acknowledge is recorded.
REQ-025 After deassertion, a DBA already high SHALL NOT generate a request; the edge registers start at 0, but the first cycle only loads them.

Configuration
REQ-026 Macro XM23_INT_RR_TIE_EN defined: ties among equal-highest priority SHALL be resolved round-robin, starting at the index after the last acknowledged device; the pointer updates in ACK.
REQ-027 Macro XM23_INT_RR_TIE_EN undefined: ties SHALL go to the lowest device index (fixed order); no pointer register exists.

Verification
REQ-028 Timer IE = 1, pri = 3, cur_pri = 0, DBA 0->1 -> pic_out = 8'hB0 on the 3rd rising edge; pic_read pulse -> pend[0] = 0 and pic_out[7] = 0 next cycle.
REQ-029 Keyboard pri = 2, push button pri = 5, both DBA rise in the same cycle, cur_pri = 0 -> pic_out = 8'hD4 first; after ack, 8'hA1.
REQ-030 Screen pri = 4, cur_pri = 4, DBA rises -> pic_out[7] stays 0; cur_pri drops to 3 -> pic_out = 8'hC2 within 3 cycles.
REQ-031 Traffic light presented (8'hB3), IE cleared before pic_read -> pic_out[7] = 0 within 1 cycle; pend[3] = 0.
REQ-032 With XM23_INT_RR_TIE_EN, timer and keyboard both pri = 1, retriggered after every ack -> vectors alternate 0,1,0,1; without the macro -> always 0 first.
REQ-033 Reset_n pulsed low while pic_out = 8'hB0 -> pic_out = 8'h00 immediately; with DBA still high after release, no request is generated.

Source files
------------

// File: rtl/xm23_int_ctrl.sv
// XM23 programmable interrupt controller: edge-detects device DBA flags into pending bits,
// arbitrates by priority and presents one vector at a time. Define XM23_INT_RR_TIE_EN for round-robin ties.
module xm23_int_ctrl #(
  parameter int          NUM_DEV   = 5,
  parameter logic [3:0]  VECT_BASE = 4'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             csr_tmr_i,
  input  logic [7:0]             csr_kb_i,
  input  logic [7:0]             csr_scr_i,
  input  logic [7:0]             csr_tl_i,
  input  logic [7:0]             csr_pb_i,
  input  logic [3*NUM_DEV-1:0]   dev_pri_i,
  input  logic [2:0]             cur_pri_i,
  input  logic                   pic_read_i,
  output logic [7:0]             pic_out_o,
  output logic [NUM_DEV-1:0]     pend_o
);

  localparam int IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_PRESENT, S_ACK} state_e;

  state_e               state_q;
  logic [IW-1:0]        win_idx_q;
  logic [2:0]           win_pri_q;
  logic [7:0]           pic_out_q;
  logic [NUM_DEV-1:0]   pend_q, pend_d;
  logic [NUM_DEV-1:0]   dba_q;
  logic                 armed_q;

  logic [NUM_DEV-1:0]   ie, dba, dba_rise, set_vec, ack_vec;
  logic [2:0]           pri_a [NUM_DEV];
  logic [2:0]           max_pri;
  logic                 found;
  logic [IW-1:0]        sel_idx;
  logic                 hit;
  logic [IW-1:0]        rr_base;
  logic                 win_live, abort, ack;

  assign ie  = NUM_DEV'({csr_pb_i[0], csr_tl_i[0], csr_scr_i[0], csr_kb_i[0], csr_tmr_i[0]});
  assign dba = NUM_DEV'({csr_pb_i[2], csr_tl_i[2], csr_scr_i[2], csr_kb_i[2], csr_tmr_i[2]});

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) pri_a[i] = dev_pri_i[3*i +: 3];
  end

`ifdef XM23_INT_RR_TIE_EN
  logic [IW-1:0] rr_ptr_q;
  assign rr_base = rr_ptr_q;
`else
  assign rr_base = '0;
`endif

  // Circular device slot k positions after base.
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_DEV) s = s - NUM_DEV;
    return IW'(s);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found   = 1'b0;
    max_pri = 3'd0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (pend_q[i] && (!found || pri_a[i] > max_pri)) begin
        found   = 1'b1;
        max_pri = pri_a[i];
      end
    end
    hit     = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (!hit && pend_q[slot(rr_base, k)] && pri_a[slot(rr_base, k)] == max_pri) begin
        hit     = 1'b1;
        sel_idx = slot(rr_base, k);
      end
    end
  end

  // A presented request is withdrawn as soon as its source disables or the CPU outranks it.
  assign win_live = pend_q[win_idx_q] & ie[win_idx_q];
  assign abort    = !win_live || (cur_pri_i >= win_pri_q);
  assign ack      = (state_q == S_PRESENT) && pic_read_i && !abort;

  assign dba_rise = dba & ~dba_q;
  assign set_vec  = dba_rise & ie & {NUM_DEV{armed_q}};
  assign ack_vec  = ack ? (NUM_DEV'(1) << win_idx_q) : '0;
  assign pend_d   = set_vec | (pend_q & ie & ~ack_vec);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      dba_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      dba_q   <= dba;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      win_idx_q <= '0;
      win_pri_q <= 3'd0;
      pic_out_q <= 8'h00;
`ifdef XM23_INT_RR_TIE_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          pic_out_q <= 8'h00;
          if (|pend_q) state_q <= S_ARB;
        end
        S_ARB: begin
          win_idx_q <= sel_idx;
          win_pri_q <= max_pri;
          if (found && max_pri > cur_pri_i) begin
            state_q   <= S_PRESENT;
            pic_out_q <= {1'b1, max_pri, VECT_BASE + 4'(sel_idx)};
          end else begin
            state_q   <= S_IDLE;
          end
        end
        S_PRESENT: begin
          if (abort) begin
            state_q   <= S_IDLE;
            pic_out_q <= 8'h00;
          end else if (pic_read_i) begin
            state_q   <= S_ACK;
            pic_out_q <= 8'h00;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
`ifdef XM23_INT_RR_TIE_EN
          rr_ptr_q <= (int'(win_idx_q) == NUM_DEV - 1) ? '0 : win_idx_q + 1'b1;
`endif
        end
        default: begin
          state_q   <= S_IDLE;
          pic_out_q <= 8'h00;
        end
      endcase
    end
  end

  assign pic_out_o = pic_out_q;
  assign pend_o    = pend_q;

endmodule

// File: tb/tb_xm23_int_ctrl.sv
// Directed bench for xm23_int_ctrl: latency, arbitration, abort, reset and tie-break scenarios.
module tb_xm23_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  csr [5];
  logic [14:0] dev_pri;
  logic [2:0]  cur_pri;
  logic        pic_read;
  logic [7:0]  pic_out;
  logic [4:0]  pend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xm23_int_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .csr_tmr_i  (csr[0]),
    .csr_kb_i   (csr[1]),
    .csr_scr_i  (csr[2]),
    .csr_tl_i   (csr[3]),
    .csr_pb_i   (csr[4]),
    .dev_pri_i  (dev_pri),
    .cur_pri_i  (cur_pri),
    .pic_read_i (pic_read),
    .pic_out_o  (pic_out),
    .pend_o     (pend)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !pic_out[7]; i++) @(negedge clk);
  endtask

  task automatic ack_pulse();
    pic_read = 1'b1;
    cyc(1);
    pic_read = 1'b0;
  endtask

  task automatic set_pri(input int dev, input int p);
    dev_pri[3*dev +: 3] = 3'(p);
  endtask

  task automatic set_ie(input int dev, input bit v);
    csr[dev][0] = v;
  endtask

  task automatic set_dba(input int dev, input bit v);
    csr[dev][2] = v;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) csr[i] = 8'h00;
    dev_pri  = '0;
    cur_pri  = 3'd0;
    pic_read = 1'b0;
    rst_n    = 1'b0;
    cyc(2);
    check("reset_pic_out", 16'(pic_out), 16'h00);
    check("reset_pend", 16'(pend), 16'h00);
    rst_n = 1'b1;
    cyc(2);

    // Timer: three-edge latency and acknowledge
    set_pri(0, 3); set_ie(0, 1);
    cyc(1);
    set_dba(0, 1);
    cyc(1);
    check("tmr_pend_edge1", 16'(pend), 16'h01);
    check("tmr_out_edge1", 16'(pic_out), 16'h00);
    cyc(1);
    check("tmr_out_edge2", 16'(pic_out), 16'h00);
    cyc(1);
    check("tmr_out_edge3", 16'(pic_out), 16'hB0);
    ack_pulse();
    check("tmr_ack_pend", 16'(pend), 16'h00);
    check("tmr_ack_out", 16'(pic_out), 16'h00);
    cyc(2);
    check("tmr_dba_held", 16'(pend), 16'h00);
    set_dba(0, 0); set_ie(0, 0);
    cyc(1);

    // Keyboard pri 2 vs push button pri 5, same cycle
    set_pri(1, 2); set_pri(4, 5); set_ie(1, 1); set_ie(4, 1);
    cyc(1);
    set_dba(1, 1); set_dba(4, 1);
    wait_valid(5);
    check("pb_first", 16'(pic_out), 16'hD4);
    check("both_pend", 16'(pend), 16'h12);
    ack_pulse();
    wait_valid(6);
    check("kb_second", 16'(pic_out), 16'hA1);
    ack_pulse();
    check("kb_pb_done", 16'(pend), 16'h00);
    set_dba(1, 0); set_dba(4, 0); set_ie(1, 0); set_ie(4, 0);
    cyc(2);

    // Screen pri 4 blocked by cur_pri 4; stray pic_read ignored
    set_pri(2, 4); cur_pri = 3'd4; set_ie(2, 1);
    cyc(1);
    set_dba(2, 1);
    cyc(6);
    check("scr_blocked_out", 16'(pic_out), 16'h00);
    check("scr_blocked_pend", 16'(pend), 16'h04);
    pic_read = 1'b1;
    cyc(1);
    pic_read = 1'b0;
    cyc(1);
    check("scr_stray_read", 16'(pend), 16'h04);
    cur_pri = 3'd3;
    wait_valid(3);
    check("scr_present", 16'(pic_out), 16'hC2);
    ack_pulse();
    cur_pri = 3'd0;
    set_dba(2, 0); set_ie(2, 0);
    cyc(2);

    // Traffic light: abort on IE clear, abort on cur_pri rise
    set_pri(3, 3); set_ie(3, 1);
    cyc(1);
    set_dba(3, 1);
    wait_valid(5);
    check("tl_present", 16'(pic_out), 16'hB3);
    set_ie(3, 0);
    cyc(1);
    check("tl_ie_abort_out", 16'(pic_out), 16'h00);
    check("tl_ie_abort_pend", 16'(pend), 16'h00);
    set_ie(3, 1); set_dba(3, 0);
    cyc(1);
    set_dba(3, 1);
    wait_valid(5);
    check("tl_present2", 16'(pic_out), 16'hB3);
    cur_pri = 3'd3;
    cyc(1);
    check("tl_pri_abort_out", 16'(pic_out), 16'h00);
    check("tl_pri_abort_pend", 16'(pend), 16'h08);
    cur_pri = 3'd0;
    wait_valid(4);
    check("tl_present3", 16'(pic_out), 16'hB3);
    ack_pulse();
    set_dba(3, 0); set_ie(3, 0);
    cyc(2);

    // Equal-priority tie between timer and keyboard
    set_pri(0, 1); set_pri(1, 1); set_ie(0, 1); set_ie(1, 1);
    for (int r = 0; r < 4; r++) begin
      logic [7:0] exp_tie;
`ifdef XM23_INT_RR_TIE_EN
      exp_tie = (r % 2 == 1) ? 8'h91 : 8'h90;
`else
      exp_tie = 8'h90;
`endif
      cur_pri = 3'd7;
      set_dba(0, 0); set_dba(1, 0);
      cyc(1);
      set_dba(0, 1); set_dba(1, 1);
      cyc(2);
      cur_pri = 3'd0;
      wait_valid(5);
      check($sformatf("tie_round%0d", r), 16'(pic_out), 16'(exp_tie));
      ack_pulse();
      cyc(1);
    end
    set_ie(0, 0); set_ie(1, 0); set_dba(0, 0); set_dba(1, 0);
    cyc(2);

    // Priority 0 is never presented
    set_pri(4, 0); set_ie(4, 1);
    cyc(1);
    set_dba(4, 1);
    cyc(6);
    check("pri0_out", 16'(pic_out), 16'h00);
    check("pri0_pend", 16'(pend), 16'h10);
    set_dba(4, 0); set_ie(4, 0);
    cyc(2);

    // Reset mid-PRESENT, DBA still high after release
    set_pri(0, 3); set_ie(0, 1);
    cyc(1);
    set_dba(0, 1);
    wait_valid(5);
    check("rst_pre_present", 16'(pic_out), 16'hB0);
    rst_n = 1'b0;
    #1;
    check("rst_async_out", 16'(pic_out), 16'h00);
    check("rst_async_pend", 16'(pend), 16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    check("rst_release_out", 16'(pic_out), 16'h00);
    check("rst_release_pend", 16'(pend), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
